// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: instruction field layout, opcodes and
// the run/halt state encoding.
package stack_cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_MSB = 25;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_PUSH = 6'h01;
    localparam logic [OPC_W-1:0] OP_POP  = 6'h02;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'h03;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'h04;
    localparam logic [OPC_W-1:0] OP_AND  = 6'h05;
    localparam logic [OPC_W-1:0] OP_OR   = 6'h06;
    localparam logic [OPC_W-1:0] OP_DUP  = 6'h07;
    localparam logic [OPC_W-1:0] OP_SWAP = 6'h08;
    localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/stack_cpu_imem.sv
// Instruction memory: a plain array read combinationally by pc. Contents are
// loaded from outside by hierarchical assignment; there is no write port.
module stack_cpu_imem #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 16
) (
    input  logic [$clog2(IMEM_DEPTH)-1:0] addr,
    output logic [DATA_W-1:0]             instr
);

    logic [DATA_W-1:0] IM [IMEM_DEPTH];

    assign instr = IM[addr];

endmodule

// File: rtl/stack_cpu.sv
// Single-cycle stack CPU: combinational fetch from imem, one instruction
// retired per clock into a register-array stack with a depth counter.
module stack_cpu
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IMEM_DEPTH  = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [$clog2(IMEM_DEPTH)-1:0]  pc,
    output logic [DATA_W-1:0]              tos,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           halted,
    output logic                           ovf,
    output logic                           unf
);

    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    logic [DATA_W-1:0] instr;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] imm;

    cpu_state_t        state, state_n;
    logic [DATA_W-1:0] stk   [STACK_DEPTH];
    logic [DATA_W-1:0] stk_n [STACK_DEPTH];
    logic [DW-1:0]     depth_n;
    logic [PW-1:0]     pc_n;
    logic              ovf_set, unf_set;

    logic [AW-1:0]     top_idx, nos_idx, push_idx;
    logic              empty, full, lt2;
    logic [DATA_W-1:0] top_val, nos_val, alu_res;

    stack_cpu_imem #(
        .DATA_W     (DATA_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) imem (
        .addr  (pc),
        .instr (instr)
    );

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign imm    = DATA_W'(instr[IMM_MSB:IMM_LSB]);

    // Indices are only used when the matching guard (empty/lt2/full) is false,
    // so truncation at the boundaries is harmless.
    assign top_idx  = AW'(depth - DW'(1));
    assign nos_idx  = AW'(depth - DW'(2));
    assign push_idx = depth[AW-1:0];
    assign empty    = (depth == '0);
    assign full     = (depth == DW'(STACK_DEPTH));
    assign lt2      = (depth < DW'(2));
    assign top_val  = stk[top_idx];
    assign nos_val  = stk[nos_idx];

    always_comb begin
        case (opcode)
            OP_SUB:  alu_res = nos_val - top_val;
            OP_AND:  alu_res = nos_val & top_val;
            OP_OR:   alu_res = nos_val | top_val;
            default: alu_res = nos_val + top_val;
        endcase
    end

    always_comb begin
        state_n = state;
        stk_n   = stk;
        depth_n = depth;
        pc_n    = pc;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (state == ST_RUN) begin
            pc_n = pc + PW'(1);
            case (opcode)
                OP_PUSH: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stk_n[push_idx] = imm;
                        depth_n         = depth + DW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) unf_set = 1'b1;
                    else       depth_n = depth - DW'(1);
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    if (lt2) begin
                        unf_set = 1'b1;
                    end else begin
                        stk_n[nos_idx] = alu_res;
                        depth_n        = depth - DW'(1);
                    end
                end
                OP_DUP: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stk_n[push_idx] = top_val;
                        depth_n         = depth + DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (lt2) begin
                        unf_set = 1'b1;
                    end else begin
                        stk_n[top_idx] = nos_val;
                        stk_n[nos_idx] = top_val;
                    end
                end
                OP_HALT: begin
                    // HALT keeps pc pointing at itself.
                    state_n = ST_HALT;
                    pc_n    = pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_RUN;
            pc    <= '0;
            depth <= '0;
            stk   <= '{default: '0};
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            depth <= depth_n;
            stk   <= stk_n;
            ovf   <= ovf | ovf_set;
            unf   <= unf | unf_set;
        end
    end

    assign tos    = empty ? '0 : top_val;
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_stack_cpu.sv
// Directed bench for stack_cpu: programs loaded into imem.IM, outputs checked
// one step at a time against hand-computed values.
module tb_stack_cpu;

    logic        clock;
    logic        reset;
    logic [3:0]  pc;
    logic [31:0] tos;
    logic [3:0]  depth;
    logic        halted;
    logic        ovf;
    logic        unf;

    int vectors    = 0;
    int miscompares = 0;

    stack_cpu dut (
        .clock  (clock),
        .reset  (reset),
        .pc     (pc),
        .tos    (tos),
        .depth  (depth),
        .halted (halted),
        .ovf    (ovf),
        .unf    (unf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_depth, input logic [31:0] e_tos);
        check({tag, ".pc"},    32'(pc),    e_pc);
        check({tag, ".depth"}, 32'(depth), e_depth);
        check({tag, ".tos"},   tos,        e_tos);
    endtask

    task automatic check_flags(input string tag, input logic e_halted,
                               input logic e_ovf, input logic e_unf);
        check({tag, ".halted"}, 32'(halted), 32'(e_halted));
        check({tag, ".ovf"},    32'(ovf),    32'(e_ovf));
        check({tag, ".unf"},    32'(unf),    32'(e_unf));
    endtask

    task automatic clear_im();
        for (int i = 0; i < 16; i++) dut.imem.IM[i] = 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        check_state("reset", 0, 0, 0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;

        // Push / add / pop-to-empty program with pc wrap
        clear_im();
        dut.imem.IM[0]  = 32'h0400_0011;
        dut.imem.IM[1]  = 32'h0400_0022;
        dut.imem.IM[2]  = 32'h0400_0033;
        dut.imem.IM[3]  = 32'h0400_0044;
        dut.imem.IM[4]  = 32'h0400_0055;
        dut.imem.IM[6]  = 32'h0C00_0000;
        dut.imem.IM[8]  = 32'h0800_0000;
        dut.imem.IM[9]  = 32'h0800_0000;
        dut.imem.IM[10] = 32'h0800_0000;
        dut.imem.IM[11] = 32'h0800_0000;
        do_reset();
        tick(5);
        check_state("push5", 5, 5, 32'h55);
        tick(2);
        check_state("add", 7, 4, 32'h99);
        tick(5);
        check_state("pop_empty", 12, 0, 0);
        check_flags("pop_empty", 1'b0, 1'b0, 1'b0);
        tick(4);
        check_state("wrap", 0, 0, 0);
        tick(1);
        check_state("rerun", 1, 1, 32'h11);

        // Overflow: nine pushes into an eight-entry stack
        clear_im();
        for (int i = 0; i < 9; i++) dut.imem.IM[i] = 32'h0400_0000 | 32'(i + 1);
        do_reset();
        tick(8);
        check_state("full", 8, 8, 32'h8);
        check_flags("full", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_state("ovf", 9, 8, 32'h8);
        check_flags("ovf", 1'b0, 1'b1, 1'b0);
        tick(1);
        check("ovf_sticky", 32'(ovf), 1);

        // Underflow: POP then ADD on an empty stack
        clear_im();
        dut.imem.IM[0] = 32'h0800_0000;
        dut.imem.IM[1] = 32'h0C00_0000;
        do_reset();
        tick(1);
        check_state("unf_pop", 1, 0, 0);
        check_flags("unf_pop", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_state("unf_add", 2, 0, 0);
        check_flags("unf_add", 1'b0, 1'b0, 1'b1);

        // ALU, DUP, SWAP, unknown opcode, SWAP underflow, HALT
        clear_im();
        dut.imem.IM[0]  = 32'h0400_00F0;
        dut.imem.IM[1]  = 32'h0400_003C;
        dut.imem.IM[2]  = 32'h2000_0000;
        dut.imem.IM[3]  = 32'h1000_0000;
        dut.imem.IM[4]  = 32'h1C00_0000;
        dut.imem.IM[5]  = 32'h04FF_00FF;
        dut.imem.IM[6]  = 32'h1400_0000;
        dut.imem.IM[7]  = 32'h1800_0000;
        dut.imem.IM[8]  = 32'h5400_0000;
        dut.imem.IM[9]  = 32'h2000_0000;
        dut.imem.IM[10] = 32'hFC00_0000;
        do_reset();
        tick(1); check_state("push_f0", 1, 1, 32'hF0);
        tick(1); check_state("push_3c", 2, 2, 32'h3C);
        tick(1); check_state("swap",    3, 2, 32'hF0);
        tick(1); check_state("sub",     4, 1, 32'hFFFF_FF4C);
        tick(1); check_state("dup",     5, 2, 32'hFFFF_FF4C);
        tick(1); check_state("push_m",  6, 3, 32'h00FF_00FF);
        tick(1); check_state("and",     7, 2, 32'h00FF_004C);
        tick(1); check_state("or",      8, 1, 32'hFFFF_FF4C);
        tick(1); check_state("badop",   9, 1, 32'hFFFF_FF4C);
        check_flags("badop", 1'b0, 1'b0, 1'b0);
        tick(1); check_state("swap_unf", 10, 1, 32'hFFFF_FF4C);
        check_flags("swap_unf", 1'b0, 1'b0, 1'b1);
        tick(1); check_state("halt", 10, 1, 32'hFFFF_FF4C);
        check_flags("halt", 1'b1, 1'b0, 1'b1);
        tick(3); check_state("halt_hold", 10, 1, 32'hFFFF_FF4C);

        // HALT at IM[2], then a one-clock reset
        clear_im();
        dut.imem.IM[0] = 32'h0400_0007;
        dut.imem.IM[1] = 32'h0400_0008;
        dut.imem.IM[2] = 32'hFC00_0000;
        do_reset();
        tick(3);
        check_state("halt2", 2, 2, 32'h8);
        check_flags("halt2", 1'b1, 1'b0, 1'b0);
        tick(2);
        check_state("halt2_hold", 2, 2, 32'h8);
        reset = 1'b0;
        tick(1);
        check_state("rst1", 0, 0, 0);
        check_flags("rst1", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1);
        check_state("after_rst", 1, 1, 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
